// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette bank and its flash timer.
// DEFAULT_PAL is the 4-bit-per-channel palette that every bank reloads on reset.
package sprite_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam int FLASH_CNT_W = 8;

    // Element 0 is the rightmost term.
    localparam logic [7:0][11:0] DEFAULT_PAL = {
        12'h621, 12'h070, 12'h05E, 12'hE30,
        12'h000, 12'hEBA, 12'h027, 12'h0E0
    };

endpackage

// File: rtl/palette_flash_timer.sv
// Damage-flash timer: loads FLASH_FRAMES on flash_start and counts frame ticks down to zero.
// flash_active comes only from the count register, so there is no path from flash_start.
module palette_flash_timer
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_tick,
    input  logic flash_start,
    output logic flash_active
);

    logic [FLASH_CNT_W-1:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (flash_start) begin
            count <= FLASH_CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign flash_active = (count != '0);

endmodule

// File: rtl/sprite_palette_bank.sv
// Writable multi-palette colour lookup for sprite pixels, with a 1-cycle registered output,
// colour-key transparency, and a frame-timed palette override for damage flashes.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W        = 3,
    parameter int NUM_PAL      = 4,
    parameter int CH_W         = 4,
    parameter int KEY_IDX      = 0,
    parameter int FLASH_FRAMES = 8,
    localparam int PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int ENT_W       = 3 * CH_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             pix_valid,
    input  logic [PAL_W-1:0] pal_sel,
    input  logic [IDX_W-1:0] index,
    input  logic             wr_en,
    input  logic [PAL_W-1:0] wr_pal,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ENT_W-1:0] wr_rgb,
    input  logic             frame_tick,
    input  logic             flash_start,
    input  logic [PAL_W-1:0] flash_pal,
    output logic             out_valid,
    output logic [CH_W-1:0]  red,
    output logic [CH_W-1:0]  green,
    output logic [CH_W-1:0]  blue,
    output logic             transparent,
    output logic             flash_active
);

    localparam int ENTRIES = 2 ** IDX_W;

    // Left-align a 4-bit default nibble into a CH_W channel, zero-filling below.
    function automatic logic [CH_W-1:0] widen(input logic [3:0] n);
        return CH_W'({n, {CH_W{1'b0}}} >> 4);
    endfunction

    function automatic logic [ENT_W-1:0] default_entry(input int i);
        rgb12_t d;
        d = '0;
        if (i < 8) d = rgb12_t'(DEFAULT_PAL[i[2:0]]);
        return {widen(d.r), widen(d.g), widen(d.b)};
    endfunction

    logic [ENT_W-1:0] mem [NUM_PAL][ENTRIES];
    logic [1:0]       vld_pipe;
    logic [PAL_W-1:0] eff_pal;
    logic             pal_ok;
    logic             wr_ok;
    logic [ENT_W-1:0] rd_rgb;

    palette_flash_timer #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_timer (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .flash_start  (flash_start),
        .flash_active (flash_active)
    );

    assign eff_pal = flash_active ? flash_pal : pal_sel;
    assign pal_ok  = (32'(eff_pal) < NUM_PAL);
    assign wr_ok   = wr_en && (32'(wr_pal) < NUM_PAL);

    // Out-of-range palettes read as black; a same-cycle write to the read slot wins.
    always_comb begin
        rd_rgb = '0;
        if (pal_ok) rd_rgb = mem[eff_pal][index];
        if (wr_ok && wr_pal == eff_pal && wr_idx == index) rd_rgb = wr_rgb;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int i = 0; i < ENTRIES; i++)
                    mem[p][i] <= default_entry(i);
        end else if (wr_ok) begin
            mem[wr_pal][wr_idx] <= wr_rgb;
        end
    end

    assign vld_pipe[0] = pix_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_pipe[1]          <= 1'b0;
            {red, green, blue}   <= '0;
            transparent          <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                {red, green, blue} <= rd_rgb;
                transparent        <= (index == IDX_W'(KEY_IDX));
            end
        end
    end

    assign out_valid = vld_pipe[1];

endmodule
